// File: rtl/rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter: round-robin arbiter of the register file write port
// (LSU vs compute) that drops writes to read-only registers and flags them.
// Optional macro RF_ARB_PERF_CNT_EN builds the grant/conflict counters.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rf_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 8,
  parameter int RO_BASE    = 13
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wb_stall,
  input  logic                            lsu_valid,
  output logic                            lsu_ready,
  input  logic [3:0]                      lsu_addr,
  input  logic [1:0]                      lsu_warp,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] lsu_data,
  input  logic                            cmp_valid,
  output logic                            cmp_ready,
  input  logic [3:0]                      cmp_addr,
  input  logic [1:0]                      cmp_warp,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] cmp_data,
  output logic                            reg_write_en,
  output logic [3:0]                      reg_write_addr,
  output logic [1:0]                      warp_num_write,
  output logic [DATA_WIDTH*NUM_LANES-1:0] reg_write_data,
  output logic                            ro_violation,
  output logic                            ro_src,
  output logic [15:0]                     perf_lsu_cnt,
  output logic [15:0]                     perf_cmp_cnt,
  output logic [15:0]                     perf_conflict_cnt
);

  localparam logic [3:0] c_RO_BASE = 4'(RO_BASE);
  localparam logic       c_LSU     = 1'b0;
  localparam logic       c_CMP     = 1'b1;

  logic                            last_grant_q;
  logic                            en_q;
  logic [3:0]                      addr_q;
  logic [1:0]                      warp_q;
  logic [DATA_WIDTH*NUM_LANES-1:0] data_q;
  logic                            ro_violation_q;
  logic                            ro_src_q;

  logic                            w_accept;
  logic                            w_winner;
  logic [3:0]                      w_win_addr;
  logic [1:0]                      w_win_warp;
  logic [DATA_WIDTH*NUM_LANES-1:0] w_win_data;
  logic                            w_win_ro;

  // On a conflict the grant goes to whoever did not win last time.
  always_comb begin
    lsu_ready = 1'b0;
    cmp_ready = 1'b0;
    if (!wb_stall) begin
      if (lsu_valid && cmp_valid) begin
        lsu_ready = (last_grant_q == c_CMP);
        cmp_ready = (last_grant_q == c_LSU);
      end else begin
        lsu_ready = lsu_valid;
        cmp_ready = cmp_valid;
      end
    end
  end

  assign w_accept   = (lsu_valid & lsu_ready) | (cmp_valid & cmp_ready);
  assign w_winner   = cmp_ready ? c_CMP : c_LSU;
  assign w_win_addr = cmp_ready ? cmp_addr : lsu_addr;
  assign w_win_warp = cmp_ready ? cmp_warp : lsu_warp;
  assign w_win_data = cmp_ready ? cmp_data : lsu_data;
  assign w_win_ro   = (w_win_addr >= c_RO_BASE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q   <= c_CMP;
      en_q           <= 1'b0;
      addr_q         <= '0;
      warp_q         <= '0;
      data_q         <= '0;
      ro_violation_q <= 1'b0;
      ro_src_q       <= 1'b0;
    end else begin
      en_q <= 1'b0;
      if (w_accept) begin
        last_grant_q <= w_winner;
        if (!w_win_ro) begin
          en_q   <= 1'b1;
          addr_q <= w_win_addr;
          warp_q <= w_win_warp;
          data_q <= w_win_data;
        end else begin
          ro_violation_q <= 1'b1;
          // Only the first offender is recorded.
          if (!ro_violation_q) ro_src_q <= w_winner;
        end
      end
    end
  end

  assign reg_write_en   = en_q;
  assign reg_write_addr = addr_q;
  assign warp_num_write = warp_q;
  assign reg_write_data = data_q;
  assign ro_violation   = ro_violation_q;
  assign ro_src         = ro_src_q;

`ifdef RF_ARB_PERF_CNT_EN
  logic [15:0] perf_lsu_q;
  logic [15:0] perf_cmp_q;
  logic [15:0] perf_conf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_lsu_q  <= '0;
      perf_cmp_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      if (lsu_valid && lsu_ready && (perf_lsu_q != 16'hFFFF))
        perf_lsu_q <= perf_lsu_q + 16'd1;
      if (cmp_valid && cmp_ready && (perf_cmp_q != 16'hFFFF))
        perf_cmp_q <= perf_cmp_q + 16'd1;
      if (lsu_valid && cmp_valid && !wb_stall && (perf_conf_q != 16'hFFFF))
        perf_conf_q <= perf_conf_q + 16'd1;
    end
  end

  assign perf_lsu_cnt      = perf_lsu_q;
  assign perf_cmp_cnt      = perf_cmp_q;
  assign perf_conflict_cnt = perf_conf_q;
`else
  assign perf_lsu_cnt      = '0;
  assign perf_cmp_cnt      = '0;
  assign perf_conflict_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rf_write_arbiter;

  localparam int c_DW = 16;
  localparam int c_NL = 8;
  localparam int c_W  = c_DW * c_NL;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           wb_stall = 1'b0;
  logic           lsu_valid = 1'b0;
  logic           lsu_ready;
  logic [3:0]     lsu_addr = '0;
  logic [1:0]     lsu_warp = '0;
  logic [c_W-1:0] lsu_data = '0;
  logic           cmp_valid = 1'b0;
  logic           cmp_ready;
  logic [3:0]     cmp_addr = '0;
  logic [1:0]     cmp_warp = '0;
  logic [c_W-1:0] cmp_data = '0;
  logic           reg_write_en;
  logic [3:0]     reg_write_addr;
  logic [1:0]     warp_num_write;
  logic [c_W-1:0] reg_write_data;
  logic           ro_violation;
  logic           ro_src;
  logic [15:0]    perf_lsu_cnt;
  logic [15:0]    perf_cmp_cnt;
  logic [15:0]    perf_conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rf_write_arbiter #(.DATA_WIDTH(c_DW), .NUM_LANES(c_NL), .RO_BASE(13)) dut (
    .clk(clk), .reset_n(reset_n), .wb_stall(wb_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
    .lsu_warp(lsu_warp), .lsu_data(lsu_data),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_addr(cmp_addr),
    .cmp_warp(cmp_warp), .cmp_data(cmp_data),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .warp_num_write(warp_num_write), .reg_write_data(reg_write_data),
    .ro_violation(ro_violation), .ro_src(ro_src),
    .perf_lsu_cnt(perf_lsu_cnt), .perf_cmp_cnt(perf_cmp_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [c_W-1:0] got, input logic [c_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [c_W-1:0] lanes(input logic [15:0] base);
    logic [c_W-1:0] v;
    for (int i = 0; i < c_NL; i++) v[i*c_DW +: c_DW] = base + 16'(i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lsu_valid = 1'b0;
    cmp_valid = 1'b0;
    wb_stall  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_en", reg_write_en, 0);
    check("rst_addr", reg_write_addr, 0);
    check("rst_warp", warp_num_write, 0);
    check("rst_data", reg_write_data, 0);
    check("rst_rov", ro_violation, 0);
    check("rst_rosrc", ro_src, 0);
    check("rst_lrdy", lsu_ready, 0);
    check("rst_crdy", cmp_ready, 0);
    do_reset();

    // Single LSU write
    lsu_valid = 1'b1; lsu_addr = 4'd3; lsu_warp = 2'd2; lsu_data = lanes(16'h0010);
    #1;
    check("t1_lrdy", lsu_ready, 1);
    check("t1_crdy", cmp_ready, 0);
    step();
    lsu_valid = 1'b0;
    check("t1_en", reg_write_en, 1);
    check("t1_addr", reg_write_addr, 3);
    check("t1_warp", warp_num_write, 2);
    check("t1_data", reg_write_data, lanes(16'h0010));
    step();
    check("t1_en_off", reg_write_en, 0);
    check("t1_addr_hold", reg_write_addr, 3);

    // Continuous conflict: LSU, cmp, LSU, cmp
    do_reset();
    lsu_valid = 1'b1; lsu_addr = 4'd1; lsu_warp = 2'd0; lsu_data = lanes(16'h0100);
    cmp_valid = 1'b1; cmp_addr = 4'd2; cmp_warp = 2'd1; cmp_data = lanes(16'h0200);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_lrdy%0d", k), lsu_ready, (k % 2 == 0));
      check($sformatf("t2_crdy%0d", k), cmp_ready, (k % 2 == 1));
      step();
      if (k == 3) begin lsu_valid = 1'b0; cmp_valid = 1'b0; end
      check($sformatf("t2_en%0d", k), reg_write_en, 1);
      check($sformatf("t2_addr%0d", k), reg_write_addr, (k % 2 == 0) ? 1 : 2);
      check($sformatf("t2_data%0d", k), reg_write_data,
            (k % 2 == 0) ? lanes(16'h0100) : lanes(16'h0200));
    end
`ifdef RF_ARB_PERF_CNT_EN
    check("t2_conf", perf_conflict_cnt, 4);
    check("t2_plsu", perf_lsu_cnt, 2);
    check("t2_pcmp", perf_cmp_cnt, 2);
`else
    check("t2_conf_tied", perf_conflict_cnt, 0);
    check("t2_plsu_tied", perf_lsu_cnt, 0);
`endif
    step();
    check("t2_en_off", reg_write_en, 0);

    // Read-only violation, first source sticks
    cmp_valid = 1'b1; cmp_addr = 4'd14; cmp_data = lanes(16'h0300);
    #1;
    check("t3_crdy", cmp_ready, 1);
    step();
    cmp_valid = 1'b0;
    check("t3_en", reg_write_en, 0);
    check("t3_rov", ro_violation, 1);
    check("t3_rosrc", ro_src, 1);
    check("t3_addr_hold", reg_write_addr, 2);
    lsu_valid = 1'b1; lsu_addr = 4'd15;
    #1;
    check("t3_lrdy", lsu_ready, 1);
    step();
    lsu_valid = 1'b0;
    check("t3b_en", reg_write_en, 0);
    check("t3b_rov", ro_violation, 1);
    check("t3b_rosrc", ro_src, 1);

    // Stall with both valid, then release; stall right after an accept
    do_reset();
    check("t4_rov_clr", ro_violation, 0);
    wb_stall = 1'b1;
    lsu_valid = 1'b1; lsu_addr = 4'd5; lsu_data = lanes(16'h0500);
    cmp_valid = 1'b1; cmp_addr = 4'd6; cmp_data = lanes(16'h0600);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t4_lrdy%0d", k), lsu_ready, 0);
      check($sformatf("t4_crdy%0d", k), cmp_ready, 0);
      step();
      check($sformatf("t4_en%0d", k), reg_write_en, 0);
    end
    wb_stall = 1'b0;
    #1;
    check("t4_rel_lrdy", lsu_ready, 1);
    check("t4_rel_crdy", cmp_ready, 0);
    step();
    wb_stall = 1'b1;
    #1;
    check("t4_en_in_stall", reg_write_en, 1);
    check("t4_addr", reg_write_addr, 5);
    check("t4_stall_crdy", cmp_ready, 0);
    step();
    check("t4_en_off", reg_write_en, 0);
    wb_stall = 1'b0;
    #1;
    check("t4_resume_crdy", cmp_ready, 1);
    lsu_valid = 1'b0; cmp_valid = 1'b0;

    // Async reset right after an accept
    lsu_valid = 1'b1; lsu_addr = 4'd7; lsu_data = lanes(16'h0700);
    step();
    lsu_valid = 1'b0;
    check("t5_en", reg_write_en, 1);
    reset_n = 1'b0;
    #1;
    check("t5_en_async", reg_write_en, 0);
    check("t5_addr_async", reg_write_addr, 0);
    step();
    reset_n = 1'b1;
    lsu_valid = 1'b1; cmp_valid = 1'b1;
    #1;
    check("t5_lrdy", lsu_ready, 1);
    check("t5_crdy", cmp_ready, 0);
    lsu_valid = 1'b0; cmp_valid = 1'b0;

`ifdef RF_ARB_PERF_CNT_EN
    // Saturation of the LSU grant counter
    do_reset();
    lsu_valid = 1'b1; lsu_addr = 4'd3;
    for (int k = 0; k < 70000; k++) step();
    lsu_valid = 1'b0;
    check("t6_plsu_sat", perf_lsu_cnt, 16'hFFFF);
    check("t6_pcmp", perf_cmp_cnt, 0);
    check("t6_conf", perf_conflict_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
